// File: rtl/pgr_uart_rx_ovs.sv
// UART receive engine: internal baud generator, 16x oversampling with a
// 3-sample majority vote, and a first-word-fall-through receive FIFO whose
// entries carry {break, parity error, framing error, data}.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   rxd_i               asynchronous serial input, idles high
//   rd_data_o           data field of the FIFO head entry (0 when empty)
//   rd_frame_err_o      head entry had a stop-bit error
//   rd_par_err_o        head entry had a parity mismatch
//   rd_break_o          head entry is a break condition
//   rd_valid_o          FIFO non-empty
//   rd_ready_i          consumer accepts the head entry
//   fifo_level_o        number of occupied entries
//   overrun_o           sticky: a word was dropped because the FIFO was full
//   ovr_clr_i           single-cycle pulse clearing overrun_o
//   rx_busy_o           receiver FSM is not idle
module pgr_uart_rx_ovs #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVS        = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rxd_i,
    output logic [DATA_BITS-1:0]            rd_data_o,
    output logic                            rd_frame_err_o,
    output logic                            rd_par_err_o,
    output logic                            rd_break_o,
    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
    output logic                            overrun_o,
    input  logic                            ovr_clr_i,
    output logic                            rx_busy_o
);
    localparam int unsigned DIV = (CLK_HZ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned EW  = DATA_BITS + 3;
    localparam int unsigned BCW = 4;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrkWait} state_e;

    // ---------------- synchroniser and edge detect ----------------
    logic rxd_meta_q, rxs_q, rxs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_i;
            rxs_q      <= rxd_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    state_e state_q, state_d;
    logic   start_edge;

    assign start_edge = (state_q == StIdle) && rxs_prev_q && !rxs_q;

    // ---------------- baud tick generator ----------------
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick;

    assign tick = (div_cnt_q == DW'(DIV - 1));

    // Reloading on the start edge aligns the sampling phase to the edge.
    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        if (start_edge || tick) div_cnt_d = '0;
    end

    // ---------------- receiver FSM ----------------
    logic [3:0]           s_q, s_d;
    logic [1:0]           smp_q, smp_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 stop0_q, stop0_d;     // every stop bit so far sampled 0
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 maj, par_calc, last_stop, brk, push;
    logic [EW-1:0]        wdata;

    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);
    assign par_calc  = (^shift_q) ^ (PARITY_ODD != 0);
    assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
    // par_bit_q is cleared at frame start, so it stays 0 when parity is disabled.
    assign brk       = (shift_q == '0) & stop0_q & ~maj & ~par_bit_q;
    assign wdata     = {brk, par_err_q, frame_err_q | ~maj, shift_q};

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        smp_d       = smp_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        stop0_d     = stop0_q;
        stop_cnt_d  = stop_cnt_q;
        push        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d     = StStart;
                    s_d         = '0;
                    bit_cnt_d   = '0;
                    stop_cnt_d  = 1'b0;
                    par_bit_d   = 1'b0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    stop0_d     = 1'b1;
                end
            end
            StBrkWait: begin
                if (rxs_q) state_d = StIdle;
            end
            default: begin
                if (tick) begin
                    s_d = s_q + 4'd1;
                    if (s_q == 4'd7) smp_d[0] = rxs_q;
                    if (s_q == 4'd8) smp_d[1] = rxs_q;
                    // Decision point: third sample is the live rxs_q.
                    if (s_q == 4'd9) begin
                        case (state_q)
                            StStart: begin
                                if (maj) state_d = StIdle;
                            end
                            StData: begin
                                shift_d = {maj, shift_q[DATA_BITS-1:1]};
                            end
                            StParity: begin
                                par_bit_d = maj;
                                par_err_d = maj ^ par_calc;
                            end
                            StStop: begin
                                if (last_stop) begin
                                    // Push mid-bit to leave half a bit for a back-to-back start.
                                    push    = 1'b1;
                                    state_d = brk ? StBrkWait : StIdle;
                                end else begin
                                    frame_err_d = frame_err_q | ~maj;
                                    stop0_d     = stop0_q & ~maj;
                                end
                            end
                            default: ;
                        endcase
                    end
                    if (s_q == 4'd15) begin
                        case (state_q)
                            StStart: state_d = StData;
                            StData: begin
                                if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                                    bit_cnt_d = '0;
                                    state_d   = (PARITY_EN != 0) ? StParity : StStop;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + BCW'(1);
                                end
                            end
                            StParity: state_d = StStop;
                            StStop:   stop_cnt_d = stop_cnt_q + 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            s_q         <= '0;
            smp_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            stop0_q     <= 1'b0;
            stop_cnt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            s_q         <= s_d;
            smp_q       <= smp_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            stop0_q     <= stop0_d;
            stop_cnt_q  <= stop_cnt_d;
        end
    end

    assign rx_busy_o = (state_q != StIdle);

    // ---------------- receive FIFO ----------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          full, pop, push_ok, overrun_q, overrun_d;
    logic [EW-1:0] head;

    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign pop     = rd_valid_o && rd_ready_i;
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - LW'(1);
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_clr_i) overrun_d = 1'b0;
        if (push && full && !pop) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign rd_valid_o   = (count_q != '0);
    assign head         = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign rd_data_o    = head[DATA_BITS-1:0];
    assign rd_frame_err_o = head[DATA_BITS];
    assign rd_par_err_o = head[DATA_BITS+1];
    assign rd_break_o   = head[DATA_BITS+2];
    assign fifo_level_o = count_q;
    assign overrun_o    = overrun_q;

endmodule
